full_adder_join_core: RTL and testbench

Full adder assembled from two cascaded half adders, with a combinational result path and an optional registered copy. It sits at the bottom of the arithmetic datapath and serves as the bit-slice from which ripple adders are composed. The WIDTH parameter chains slices into a ripple-carry adder. The default WIDTH=1 is the classic single-bit full adder.

---
 rtl/full_adder_join_core_pkg.sv | 4 +
 rtl/full_adder_join_core_half_adder.sv | 10 +
 rtl/full_adder_join_core.sv | 60 ++++++
 tb/tb_full_adder_join_core.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/full_adder_join_core_pkg.sv
// Shared constants for the full_adder_join_core bit-slice adder.
package full_adder_join_core_pkg;
    localparam int DEFAULT_WIDTH = 1;
endpackage

// File: rtl/full_adder_join_core_half_adder.sv
// Half adder: sum and generate of two single-bit operands.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic co
);
    assign s  = x ^ y;
    assign co = x & y;
endmodule

// File: rtl/full_adder_join_core.sv
// Ripple-carry adder built from full-adder slices, each made of two half adders,
// with a combinational result and a registered copy qualified by in_valid.
module full_adder_join_core
    import full_adder_join_core_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             in_valid,
    output logic [WIDTH-1:0] fsum,
    output logic             fcarry_out,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q,
    output logic             valid_q
);
    // k[i] is the carry into slice i; k[WIDTH] is the carry out of the MSB slice.
    logic [WIDTH:0]   k;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g1;
    logic [WIDTH-1:0] g2;

    assign k[0] = c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        half_adder ha1 (
            .x  (a[i]),
            .y  (b[i]),
            .s  (p[i]),
            .co (g1[i])
        );
        half_adder ha2 (
            .x  (p[i]),
            .y  (k[i]),
            .s  (fsum[i]),
            .co (g2[i])
        );
        assign k[i+1] = g1[i] | g2[i];
    end

    assign fcarry_out = k[WIDTH];

    // Result registers hold when in_valid is low; valid_q marks a fresh capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                sum_q   <= fsum;
                carry_q <= fcarry_out;
            end
        end
    end
endmodule

// File: tb/tb_full_adder_join_core.sv
// Self-checking bench for full_adder_join_core at WIDTH=1 and WIDTH=8.
module tb_full_adder_join_core;
    logic       clk;
    logic       run_clk;
    logic       rst;
    logic       c;
    logic       in_valid;
    logic       a1, b1;
    logic [7:0] a8, b8;

    logic       fsum1, fcarry1, sum_q1, carry_q1, valid_q1;
    logic [7:0] fsum8, sum_q8;
    logic       fcarry8, carry_q8, valid_q8;

    int checks_total;
    int checks_passed;

    logic [1:0] exp1_q[$];
    logic [8:0] exp8_q[$];

    full_adder_join_core #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c), .in_valid(in_valid),
        .fsum(fsum1), .fcarry_out(fcarry1), .sum_q(sum_q1),
        .carry_q(carry_q1), .valid_q(valid_q1)
    );

    full_adder_join_core #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c), .in_valid(in_valid),
        .fsum(fsum8), .fcarry_out(fcarry8), .sum_q(sum_q8),
        .carry_q(carry_q8), .valid_q(valid_q8)
    );

    // Clock can be held idle to show the combinational path needs no clock.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (run_clk) clk = ~clk;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        if (obs !== exp)
            $display("FAIL %s: got %0h required %0h", tag, obs, exp);
        else
            checks_passed++;
    endtask

    function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y, input logic ci);
        return {1'b0, x} + {1'b0, y} + {8'd0, ci};
    endfunction

    // Drive one capture at the falling edge, check the combinational result,
    // then compare the registered result after the rising edge.
    task automatic drive_capture(input logic xa1, input logic xb1,
                                 input logic [7:0] xa8, input logic [7:0] xb8,
                                 input logic ci);
        logic [1:0] e1;
        logic [8:0] e8;
        @(negedge clk);
        a1 = xa1; b1 = xb1; a8 = xa8; b8 = xb8; c = ci; in_valid = 1'b1;
        exp1_q.push_back({1'b0, xa1} + {1'b0, xb1} + {1'b0, ci});
        exp8_q.push_back(ref_add8(xa8, xb8, ci));
        #1;
        check("fsum8_comb", {fcarry8, fsum8}, ref_add8(xa8, xb8, ci));
        @(posedge clk);
        #1;
        e1 = exp1_q.pop_front();
        e8 = exp8_q.pop_front();
        check("w1_reg", {valid_q1, carry_q1, sum_q1}, {1'b1, e1});
        check("w8_reg", {valid_q8, carry_q8, sum_q8}, {1'b1, e8});
    endtask

    initial begin
        logic [7:0] sum_tab;
        logic [7:0] carry_tab;
        logic [7:0] ra, rb;
        logic       rc;
        checks_total  = 0;
        checks_passed = 0;
        sum_tab   = 8'b1001_0110;
        carry_tab = 8'b1110_1000;
        run_clk  = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a1 = 1'b0; b1 = 1'b0; c = 1'b0; a8 = 8'h00; b8 = 8'h00;
        #1;
        check("reset_w1", {valid_q1, carry_q1, sum_q1}, 3'b000);
        check("reset_w8", {valid_q8, carry_q8, sum_q8}, 10'h000);

        // Exhaustive single-bit truth table with the clock idle.
        for (int i = 0; i < 8; i++) begin
            a1 = i[2]; b1 = i[1]; c = i[0];
            #5;
            check("w1_fsum", fsum1, sum_tab[i]);
            check("w1_fcarry", fcarry1, carry_tab[i]);
        end

        // WIDTH=8 boundary patterns, still no clock.
        a8 = 8'hFF; b8 = 8'h01; c = 1'b0;
        #5;
        check("w8_ff_01", {fcarry8, fsum8}, 9'h100);
        a8 = 8'h55; b8 = 8'hAA; c = 1'b1;
        #5;
        check("w8_55_aa_c", {fcarry8, fsum8}, 9'h100);

        // Edges while reset is held are ignored.
        run_clk = 1'b1;
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; c = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("rst_hold_w1", {valid_q1, carry_q1, sum_q1}, 3'b000);
        check("rst_hold_w8", {valid_q8, carry_q8, sum_q8}, 10'h000);
        @(negedge clk);
        rst = 1'b0;

        // First capture after release: 1+1+0.
        drive_capture(1'b1, 1'b1, 8'hFF, 8'h01, 1'b0);
        check("first_cap_w1", {valid_q1, carry_q1, sum_q1}, 3'b110);
        drive_capture(1'b1, 1'b0, 8'h55, 8'hAA, 1'b1);

        for (int n = 0; n < 20; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            drive_capture(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rb, rc);
        end

        // Hold: capture 3+4, then drop in_valid and change inputs.
        drive_capture(1'b0, 1'b1, 8'h03, 8'h04, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        a8 = 8'hF0; b8 = 8'h3C; c = 1'b1;
        @(posedge clk);
        #1;
        check("hold_sum", sum_q8, 8'h07);
        check("hold_carry", carry_q8, 1'b0);
        check("hold_valid", valid_q8, 1'b0);
        check("hold_fsum", {fcarry8, fsum8}, 9'h12D);

        // Asynchronous reset between edges with a pending capture.
        @(negedge clk);
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_w8", {valid_q8, carry_q8, sum_q8}, 10'h000);
        check("async_rst_w1", {valid_q1, carry_q1, sum_q1}, 3'b000);
        check("async_rst_fsum", {fcarry8, fsum8}, 9'h12D);
        @(posedge clk);
        #1;
        check("rst_discard", {valid_q8, carry_q8, sum_q8}, 10'h000);
        @(negedge clk);
        rst = 1'b0;
        drive_capture(1'b1, 1'b1, 8'h80, 8'h80, 1'b1);

        run_clk = 1'b0;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
